// File: rtl/dp_pkg.sv
// Shared encodings for the add/sub datapath issue controller: opcodes, field positions,
// FSM states and the issue-slot record.
package dp_pkg;
   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_ADDI = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   localparam int OP_LSB  = 30;
   localparam int SUB_BIT = 29;
   localparam int WA_LSB  = 24;
   localparam int RA0_LSB = 19;
   localparam int RA1_LSB = 14;
   localparam int IM_LSB  = 0;
   localparam int REG_W   = 5;
   localparam int IM_W    = 16;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   typedef struct packed {
      logic [REG_W-1:0] ra0;
      logic [REG_W-1:0] ra1;
      logic [REG_W-1:0] wa;
      logic             alu_src;
      logic             add_sub;
      logic [IM_W-1:0]  im;
      logic             busy;
   } issue_t;

   // Idle slot: the datapath write (always enabled) lands in the scratch register.
   function automatic issue_t nop_issue(input logic [REG_W-1:0] sink);
      issue_t n;
      n         = '0;
      n.wa      = sink;
      return n;
   endfunction

   function automatic issue_t decode(input logic [31:0] w, input logic [REG_W-1:0] sink);
      issue_t d;
      d = nop_issue(sink);
      if (w[OP_LSB +: 2] == OP_ADD) begin
         d.ra0     = w[RA0_LSB +: REG_W];
         d.ra1     = w[RA1_LSB +: REG_W];
         d.wa      = w[WA_LSB +: REG_W];
         d.add_sub = w[SUB_BIT];
         d.busy    = 1'b1;
      end else if (w[OP_LSB +: 2] == OP_ADDI) begin
         d.ra0     = w[RA0_LSB +: REG_W];
         d.wa      = w[WA_LSB +: REG_W];
         d.alu_src = 1'b1;
         d.add_sub = w[SUB_BIT];
         d.im      = w[IM_LSB +: IM_W];
         d.busy    = 1'b1;
      end
      return d;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; pushes when full and pops when
// empty are dropped. Async active-low reset clears pointers and count.
module sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; contents are only observable behind the count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/dp_issue_ctrl.sv
// Issue stage for the add/sub regfile datapath: buffers instruction words, issues one
// registered control set per cycle and accumulates retire status.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_RUN    | pop FIFO head into the issue slot each cycle (NOP if empty)
//   ST_HALTED | HALT was issued; slot holds NOP until i_Resume
module dp_issue_ctrl
   import dp_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int SINK_REG = 0
) (
   input  logic        i_CLK,
   input  logic        i_RST,
   input  logic [31:0] i_Instr,
   input  logic        i_Valid,
   output logic        o_Ready,
   input  logic        i_Resume,
   input  logic        i_StatClr,
   input  logic        i_Cout,
   input  logic        i_Overflow,
   output logic [4:0]  o_RA0,
   output logic [4:0]  o_RA1,
   output logic [4:0]  o_WA,
   output logic        o_ALUSrc,
   output logic        o_AddSub,
   output logic [15:0] o_Im,
   output logic        o_Busy,
   output logic        o_Halted,
   output logic        o_CoutSticky,
   output logic        o_OvfSticky,
   output logic [15:0] o_RetCnt
);
   localparam logic [REG_W-1:0] SINK = REG_W'(SINK_REG);

   state_t      state;
   issue_t      iss;
   logic [31:0] head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;
   logic        cout_sticky;
   logic        ovf_sticky;
   logic [15:0] ret_cnt;

   assign pop     = (state == ST_RUN) & ~fifo_empty;
   assign o_Ready = ~fifo_full;

   sync_fifo #(
      .DATA_W (32),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (i_CLK),
      .rst_n (i_RST),
      .push  (i_Valid),
      .din   (i_Instr),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state <= ST_RUN;
         iss   <= nop_issue(SINK);
      end else if (state == ST_RUN) begin
         if (pop) begin
            iss <= decode(head, SINK);
            if (head[OP_LSB +: 2] == OP_HALT) state <= ST_HALTED;
         end else begin
            iss <= nop_issue(SINK);
         end
      end else begin
         iss <= nop_issue(SINK);
         if (i_Resume) state <= ST_RUN;
      end
   end

   // Clear wins over a retire on the same edge.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         cout_sticky <= 1'b0;
         ovf_sticky  <= 1'b0;
         ret_cnt     <= '0;
      end else if (i_StatClr) begin
         cout_sticky <= 1'b0;
         ovf_sticky  <= 1'b0;
         ret_cnt     <= '0;
      end else if (iss.busy) begin
         cout_sticky <= cout_sticky | i_Cout;
         ovf_sticky  <= ovf_sticky | i_Overflow;
         ret_cnt     <= ret_cnt + 16'd1;
      end
   end

   assign o_RA0        = iss.ra0;
   assign o_RA1        = iss.ra1;
   assign o_WA         = iss.wa;
   assign o_ALUSrc     = iss.alu_src;
   assign o_AddSub     = iss.add_sub;
   assign o_Im         = iss.im;
   assign o_Busy       = iss.busy;
   assign o_Halted     = (state == ST_HALTED);
   assign o_CoutSticky = cout_sticky;
   assign o_OvfSticky  = ovf_sticky;
   assign o_RetCnt     = ret_cnt;
endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Self-checking bench for dp_issue_ctrl: accepted words are decoded into an expected
// queue and popped by a monitor whenever the issue slot reports a real instruction.
module tb_dp_issue_ctrl;
   localparam int SINK = 0;

   logic        i_CLK = 1'b0;
   logic        i_RST = 1'b0;
   logic [31:0] i_Instr = '0;
   logic        i_Valid = 1'b0;
   logic        i_Resume = 1'b0;
   logic        i_StatClr = 1'b0;
   logic        i_Cout = 1'b0;
   logic        i_Overflow = 1'b0;
   logic        o_Ready;
   logic [4:0]  o_RA0, o_RA1, o_WA;
   logic        o_ALUSrc, o_AddSub, o_Busy, o_Halted, o_CoutSticky, o_OvfSticky;
   logic [15:0] o_Im, o_RetCnt;

   always #5 i_CLK = ~i_CLK;

   dp_issue_ctrl #(.DEPTH(4), .SINK_REG(SINK)) dut (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_Instr(i_Instr), .i_Valid(i_Valid), .o_Ready(o_Ready),
      .i_Resume(i_Resume), .i_StatClr(i_StatClr), .i_Cout(i_Cout), .i_Overflow(i_Overflow),
      .o_RA0(o_RA0), .o_RA1(o_RA1), .o_WA(o_WA), .o_ALUSrc(o_ALUSrc), .o_AddSub(o_AddSub),
      .o_Im(o_Im), .o_Busy(o_Busy), .o_Halted(o_Halted), .o_CoutSticky(o_CoutSticky),
      .o_OvfSticky(o_OvfSticky), .o_RetCnt(o_RetCnt)
   );

   typedef struct {
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [4:0]  wa;
      logic        alu_src;
      logic        add_sub;
      logic [15:0] im;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;

   function automatic logic [31:0] mk_add(input logic sub, input logic [4:0] wa, input logic [4:0] ra0,
                                          input logic [4:0] ra1);
      return {2'b01, sub, wa, ra0, ra1, 14'd0};
   endfunction

   function automatic logic [31:0] mk_addi(input logic sub, input logic [4:0] wa, input logic [4:0] ra0,
                                           input logic [15:0] im);
      return {2'b10, sub, wa, ra0, 3'd0, im};
   endfunction

   task automatic model_push(input logic [31:0] w);
      exp_t x;
      if (w[31:30] == 2'b01) begin
         x.ra0 = w[23:19]; x.ra1 = w[18:14]; x.wa = w[28:24];
         x.alu_src = 1'b0; x.add_sub = w[29]; x.im = 16'd0;
         exp_q.push_back(x);
      end else if (w[31:30] == 2'b10) begin
         x.ra0 = w[23:19]; x.ra1 = 5'd0; x.wa = w[28:24];
         x.alu_src = 1'b1; x.add_sub = w[29]; x.im = w[15:0];
         exp_q.push_back(x);
      end
   endtask

   always @(negedge i_CLK) begin
      if (mon_en && i_RST) begin
         n_tests++;
         if (o_Busy) begin
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL issue_unexpected: busy with wa=%0d, expected no instruction", o_WA);
            end else begin
               e = exp_q.pop_front();
               if ({o_RA0, o_RA1, o_WA, o_ALUSrc, o_AddSub, o_Im} !==
                   {e.ra0, e.ra1, e.wa, e.alu_src, e.add_sub, e.im}) begin
                  n_fail++;
                  $display("FAIL issue_fields: got ra0=%0d ra1=%0d wa=%0d src=%0b sub=%0b im=%h, expected ra0=%0d ra1=%0d wa=%0d src=%0b sub=%0b im=%h",
                           o_RA0, o_RA1, o_WA, o_ALUSrc, o_AddSub, o_Im,
                           e.ra0, e.ra1, e.wa, e.alu_src, e.add_sub, e.im);
               end
            end
         end else if ({o_WA, o_RA0, o_RA1, o_ALUSrc, o_AddSub, o_Im} !==
                      {5'(SINK), 5'd0, 5'd0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL idle_nop: got wa=%0d ra0=%0d ra1=%0d src=%0b sub=%0b im=%h, expected NOP to sink %0d",
                     o_WA, o_RA0, o_RA1, o_ALUSrc, o_AddSub, o_Im, SINK);
         end
      end
   end

   // Called at a negedge; returns at the following negedge.
   task automatic drive_cycle(input logic v, input logic [31:0] w, output bit acc);
      i_Valid = v;
      i_Instr = w;
      acc = v && o_Ready;
      @(posedge i_CLK);
      if (acc) model_push(w);
      @(negedge i_CLK);
      i_Valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] w);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) drive_cycle(1'b1, w, acc);
      n_tests++;
      if (!acc) begin
         n_fail++;
         $display("FAIL send_timeout: word %h accepted=%0b, expected 1", w, acc);
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) drive_cycle(1'b0, 32'd0, acc);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 5; i++) begin
         chk("rst_ready", 32'(o_Ready), 32'd1);
         chk("rst_wa", 32'(o_WA), 32'(SINK));
         chk("rst_busy", 32'(o_Busy), 32'd0);
         chk("rst_retcnt", 32'(o_RetCnt), 32'd0);
         chk("rst_halted", 32'(o_Halted), 32'd0);
         chk("rst_sticky", {30'd0, o_CoutSticky, o_OvfSticky}, 32'd0);
         idle(1);
      end
   endtask

   task automatic test_addi;
      send(mk_addi(1'b0, 5'd3, 5'd0, 16'hFFFE));
      idle(1);
      chk("addi_alusrc", 32'(o_ALUSrc), 32'd1);
      chk("addi_im", 32'(o_Im), 32'h0000FFFE);
      chk("addi_wa", 32'(o_WA), 32'd3);
      chk("addi_busy", 32'(o_Busy), 32'd1);
      idle(1);
      chk("addi_retcnt", 32'(o_RetCnt), 32'd1);
      chk("addi_busy_after", 32'(o_Busy), 32'd0);
   endtask

   task automatic test_halt_fill;
      logic [31:0] w[6];
      int idx;
      bit acc;
      for (int i = 0; i < 6; i++) w[i] = mk_addi(1'(i), 5'(i + 8), 5'(i), 16'h0100 + 16'(i));
      send(32'hC000_0000);
      idle(1);
      chk("fill_halted", 32'(o_Halted), 32'd1);
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         drive_cycle(1'b1, w[idx], acc);
         if (acc) idx++;
         chk("fill_busy_halted", 32'(o_Busy), 32'd0);
      end
      chk("fill_accepted", 32'(idx), 32'd4);
      chk("fill_ready_full", 32'(o_Ready), 32'd0);
      i_Resume = 1'b1;
      drive_cycle(1'b1, w[idx], acc);
      i_Resume = 1'b0;
      chk("fill_resume_noacc", 32'(acc), 32'd0);
      chk("fill_resume_state", 32'(o_Halted), 32'd0);
      chk("fill_resume_busy", 32'(o_Busy), 32'd0);
      for (int c = 0; c < 7; c++) begin
         drive_cycle(idx < 6, (idx < 6) ? w[idx] : 32'd0, acc);
         if (acc) idx++;
         chk("fill_issue_busy", 32'(o_Busy), (c < 6) ? 32'd1 : 32'd0);
      end
      chk("fill_all_accepted", 32'(idx), 32'd6);
      chk("fill_retcnt", 32'(o_RetCnt), 32'd7);
   endtask

   task automatic test_status;
      i_StatClr = 1'b1;
      idle(1);
      i_StatClr = 1'b0;
      chk("stat_clr_cnt", 32'(o_RetCnt), 32'd0);
      send(mk_add(1'b1, 5'd5, 5'd1, 5'd2));
      idle(1);
      chk("stat_add_busy", 32'(o_Busy), 32'd1);
      chk("stat_add_sub", 32'(o_AddSub), 32'd1);
      i_Overflow = 1'b1;
      idle(1);
      i_Overflow = 1'b0;
      chk("stat_ovf_set", 32'(o_OvfSticky), 32'd1);
      chk("stat_cout_clear", 32'(o_CoutSticky), 32'd0);
      chk("stat_retcnt1", 32'(o_RetCnt), 32'd1);
      i_Cout = 1'b1;
      idle(2);
      i_Cout = 1'b0;
      chk("stat_cout_ignored_idle", 32'(o_CoutSticky), 32'd0);
      send(mk_add(1'b0, 5'd6, 5'd3, 5'd4));
      idle(1);
      chk("stat_add2_busy", 32'(o_Busy), 32'd1);
      i_StatClr = 1'b1;
      i_Overflow = 1'b1;
      i_Cout = 1'b1;
      idle(1);
      i_StatClr = 1'b0;
      i_Overflow = 1'b0;
      i_Cout = 1'b0;
      chk("stat_clr_prio_ovf", 32'(o_OvfSticky), 32'd0);
      chk("stat_clr_prio_cout", 32'(o_CoutSticky), 32'd0);
      chk("stat_clr_prio_cnt", 32'(o_RetCnt), 32'd0);
   endtask

   task automatic test_halt_stream;
      send(32'd0);
      send(32'hC000_0000);
      send(mk_add(1'b0, 5'd7, 5'd1, 5'd1));
      for (int i = 0; i < 5; i++) begin
         chk("hs_halted", 32'(o_Halted), 32'd1);
         chk("hs_busy", 32'(o_Busy), 32'd0);
         chk("hs_wa_sink", 32'(o_WA), 32'(SINK));
         idle(1);
      end
      i_Resume = 1'b1;
      idle(1);
      i_Resume = 1'b0;
      chk("hs_resume_busy", 32'(o_Busy), 32'd0);
      chk("hs_resume_halted", 32'(o_Halted), 32'd0);
      idle(1);
      chk("hs_add_busy", 32'(o_Busy), 32'd1);
      chk("hs_add_wa", 32'(o_WA), 32'd7);
      idle(1);
      chk("hs_retcnt", 32'(o_RetCnt), 32'd1);
   endtask

   task automatic test_reset_mid;
      send(32'hC000_0000);
      for (int i = 0; i < 4; i++) send(mk_addi(1'b0, 5'(20 + i), 5'(i), 16'h0A00 + 16'(i)));
      chk("rm_full", 32'(o_Ready), 32'd0);
      i_Resume = 1'b1;
      idle(1);
      i_Resume = 1'b0;
      idle(1);
      chk("rm_busy_before", 32'(o_Busy), 32'd1);
      #2;
      i_RST = 1'b0;
      #1;
      chk("rm_busy", 32'(o_Busy), 32'd0);
      chk("rm_wa", 32'(o_WA), 32'(SINK));
      chk("rm_ctl", {o_RA0, o_RA1, o_ALUSrc, o_AddSub, o_Im}, 32'd0);
      chk("rm_halted", 32'(o_Halted), 32'd0);
      chk("rm_retcnt", 32'(o_RetCnt), 32'd0);
      chk("rm_ready", 32'(o_Ready), 32'd1);
      exp_q.delete();
      @(negedge i_CLK);
      @(negedge i_CLK);
      i_RST = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         chk("rm_post_busy", 32'(o_Busy), 32'd0);
         chk("rm_post_retcnt", 32'(o_RetCnt), 32'd0);
      end
   endtask

   initial begin
      repeat (2) @(negedge i_CLK);
      i_RST = 1'b1;
      mon_en = 1'b1;
      test_reset();
      test_addi();
      test_halt_fill();
      test_status();
      test_halt_stream();
      test_reset_mid();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
